// File: rtl/video_mem_scheduler.sv
// video_mem_scheduler: slot/priority arbiter for the shared graphics memory port.
// One outstanding transaction, timeout abort, per-frame missed-slot statistics.
module video_mem_scheduler #(
  parameter int TIMEOUT = 63,
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_pixel,
  input  logic [8:0]    hcnt,
  input  logic [8:0]    vcnt,
  input  logic          hblank,
  input  logic          vblank,
  input  logic [3:0]    req,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [AW-1:0] req_addr2,
  input  logic [AW-1:0] req_addr3,
  output logic [3:0]    ack,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  output logic [3:0]    grant,
  output logic          err,
  output logic [15:0]   miss_last
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [7:0]    tcnt;
  logic [1:0]    rr;
  logic [15:0]   miss_cnt;
  logic          active;
  logic          hbl;
  logic [1:0]    slot;
  logic [2:0]    rr_pick;
  logic [1:0]    rr_next;
  logic [3:0]    win;
  logic [AW-1:0] win_addr;
  logic          own_req;
  logic          miss;
  logic          frame;

  assign active = !hblank && !vblank;
  assign hbl    = hblank && !vblank;
  assign slot   = hcnt[1:0];

  // rr names the requester with highest priority for the next slot 3
  always_comb begin
    rr_pick = '0;
    unique case (rr)
      2'd1: rr_pick = req[1] ? 3'b010 : req[2] ? 3'b100 :
                      req[0] ? 3'b001 : 3'b000;
      2'd2: rr_pick = req[2] ? 3'b100 : req[0] ? 3'b001 :
                      req[1] ? 3'b010 : 3'b000;
      default: rr_pick = req[0] ? 3'b001 : req[1] ? 3'b010 :
                         req[2] ? 3'b100 : 3'b000;
    endcase
  end

  always_comb begin
    rr_next = 2'd0;
    if (rr_pick[0]) rr_next = 2'd1;
    else if (rr_pick[1]) rr_next = 2'd2;
  end

  always_comb begin
    win = '0;
    unique case (1'b1)
      vblank: win = req[3] ? 4'b1000 : req[2] ? 4'b0100 :
                    req[0] ? 4'b0001 : req[1] ? 4'b0010 : 4'b0000;
      hbl: win = req[2] ? 4'b0100 : req[0] ? 4'b0001 :
                 req[1] ? 4'b0010 : 4'b0000;
      active: begin
        if (ce_pixel) begin
          if (slot == 2'd3) win = {1'b0, rr_pick};
          else win = req & (4'b0001 << slot);
        end
      end
      default: win = '0;
    endcase
  end

  always_comb begin
    win_addr = req_addr0;
    unique case (1'b1)
      win[1]: win_addr = req_addr1;
      win[2]: win_addr = req_addr2;
      win[3]: win_addr = req_addr3;
      default: win_addr = req_addr0;
    endcase
  end

  assign own_req = (slot == 2'd3) ? |req[2:0] : req[slot];
  assign miss    = ce_pixel && active && own_req && (state == BUSY);
  assign frame   = ce_pixel && (vcnt == 9'd0) && (hcnt == 9'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ack       <= '0;
      err       <= 1'b0;
      tcnt      <= '0;
      rr        <= 2'd0;
      miss_cnt  <= '0;
      miss_last <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      if (frame) begin
        miss_last <= miss_cnt;
        miss_cnt  <= {15'd0, miss};
      end else if (miss && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
      unique case (state)
        IDLE: begin
          if (|win) begin
            state    <= BUSY;
            grant    <= win;
            mem_req  <= 1'b1;
            mem_addr <= win_addr;
            tcnt     <= 8'd1;
            if (active && slot == 2'd3) rr <= rr_next;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            ack     <= grant;
            grant   <= '0;
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (tcnt == 8'(TIMEOUT)) begin
            err     <= 1'b1;
            grant   <= '0;
            mem_req <= 1'b0;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_mem_scheduler.sv
// tb_video_mem_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_video_mem_scheduler;

  localparam int TO = 63;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce_pixel;
  logic [8:0]    hcnt;
  logic [8:0]    vcnt;
  logic          hblank;
  logic          vblank;
  logic [3:0]    req;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [AW-1:0] req_addr2;
  logic [AW-1:0] req_addr3;
  logic [3:0]    ack;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [3:0]    grant;
  logic          err;
  logic [15:0]   miss_last;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int            m_owner = -1;
  int            m_busy = 0;
  int            m_rr = 0;
  int            m_miss = 0;
  int            m_last = 0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0]    e_ack = '0;
  logic          e_err = 1'b0;

  logic [3:0] exp_rr[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
  logic [3:0] exp_vb[4] = '{4'b1000, 4'b0100, 4'b0001, 4'b0010};
  int pv[4] = '{3, 2, 0, 1};
  int ph[3] = '{2, 0, 1};

  always #5 clk = ~clk;

  video_mem_scheduler #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ce_pixel(ce_pixel),
    .hcnt(hcnt),
    .vcnt(vcnt),
    .hblank(hblank),
    .vblank(vblank),
    .req(req),
    .req_addr0(req_addr0),
    .req_addr1(req_addr1),
    .req_addr2(req_addr2),
    .req_addr3(req_addr3),
    .ack(ack),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .grant(grant),
    .err(err),
    .miss_last(miss_last)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(int n);
    case (n)
      0: return req_addr0;
      1: return req_addr1;
      2: return req_addr2;
      default: return req_addr3;
    endcase
  endfunction

  task automatic set_addr(int n, logic [AW-1:0] a);
    case (n)
      0: req_addr0 = a;
      1: req_addr1 = a;
      2: req_addr2 = a;
      default: req_addr3 = a;
    endcase
  endtask

  // one clock of the reference: inputs as currently driven, state before edge
  task automatic model_step();
    int  win;
    int  s;
    bit  busy;
    bit  act;
    bit  own;
    bit  mis;
    e_ack = '0;
    e_err = 1'b0;
    if (!reset_n) begin
      m_owner = -1; m_busy = 0; m_rr = 0;
      m_miss = 0; m_last = 0; m_addr = '0;
      return;
    end
    busy = (m_owner >= 0);
    act  = !hblank && !vblank;
    s    = int'(hcnt % 4);
    own  = (s < 3) ? req[s] : (req[0] | req[1] | req[2]);
    mis  = ce_pixel && act && own && busy;
    if (ce_pixel && vcnt == 0 && hcnt == 0) begin
      m_last = m_miss;
      m_miss = mis ? 1 : 0;
    end else if (mis && m_miss < 65535) begin
      m_miss++;
    end
    if (busy) begin
      if (mem_ack) begin
        e_ack[m_owner] = 1'b1;
        m_owner = -1;
      end else begin
        m_busy++;
        if (m_busy == TO) begin
          e_err = 1'b1;
          m_owner = -1;
        end
      end
    end else begin
      win = -1;
      if (vblank) begin
        foreach (pv[i]) if (win < 0 && req[pv[i]]) win = pv[i];
      end else if (hblank) begin
        foreach (ph[i]) if (win < 0 && req[ph[i]]) win = ph[i];
      end else if (ce_pixel) begin
        if (s < 3) begin
          if (req[s]) win = s;
        end else begin
          for (int k = 0; k < 3; k++)
            if (win < 0 && req[(m_rr + k) % 3]) win = (m_rr + k) % 3;
          if (win >= 0) m_rr = (win + 1) % 3;
        end
      end
      if (win >= 0) begin
        m_owner = win;
        m_addr  = addr_of(win);
        m_busy  = 0;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("mem_req", 32'(mem_req), 32'(m_owner >= 0));
    check("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("ack", 32'(ack), 32'(e_ack));
    check("err", 32'(err), 32'(e_err));
    check("miss_last", 32'(miss_last), 32'(m_last));
  endtask

  task automatic settle();
    reset_n = 1'b0; mem_ack = 1'b0; ce_pixel = 1'b0; req = '0;
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic rand_drive(int ack_pct);
    int r;
    for (int n = 0; n < 4; n++) begin
      if (ack[n] && $urandom_range(0, 1) == 1) req[n] = 1'b0;
      if (!req[n] && $urandom_range(0, 3) == 0) begin
        req[n] = 1'b1;
        set_addr(n, AW'($urandom));
      end
    end
    r = int'($urandom_range(0, 9));
    hblank = (r >= 6 && r < 8) || (r == 9);
    vblank = (r >= 8);
    ce_pixel = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 19) == 0) begin
      hcnt = 9'd0; vcnt = 9'd0;
    end else begin
      hcnt = 9'($urandom_range(0, 15));
      vcnt = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 261));
    end
    mem_ack = (int'($urandom_range(0, 99)) < ack_pct);
    reset_n = ($urandom_range(0, 399) != 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; ce_pixel = 1'b0; hcnt = '0; vcnt = '0;
    hblank = 1'b0; vblank = 1'b0; req = '0; mem_ack = 1'b0;
    req_addr0 = 22'h000111; req_addr1 = 22'h000222;
    req_addr2 = 22'h000333; req_addr3 = 22'h000444;
    cyc();
    cyc();
    reset_n = 1'b1;

    // active region, fixed slots then round-robin slot 3
    settle();
    req = 4'hF; vcnt = 9'd20;
    for (int i = 0; i < 4; i++) begin
      ce_pixel = 1'b1; hcnt = 9'(8 + i);
      cyc();
      check("rr_grant", 32'(grant), 32'(exp_rr[i]));
      ce_pixel = 1'b0; mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
    end

    // vblank priority with requesters leaving once served
    settle();
    req = 4'hF; vblank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("vb_grant", 32'(grant), 32'(exp_vb[i]));
      mem_ack = 1'b1;
      cyc();
      check("vb_ack", 32'(ack), 32'(exp_vb[i]));
      req = req & ~ack;
      mem_ack = 1'b0;
    end
    cyc();
    check("vb_ack_width", 32'(ack), 32'd0);

    // hblank starves cpu until vblank
    settle();
    vblank = 1'b0; hblank = 1'b1; req = 4'b1100;
    cyc();
    check("hb_sprite", 32'(grant), 32'h4);
    mem_ack = 1'b1;
    cyc();
    req = req & ~ack; mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("cpu_starve", 32'(grant), 32'd0);
    end
    vblank = 1'b1;
    cyc();
    check("cpu_vblank", 32'(grant), 32'h8);
    mem_ack = 1'b1;
    cyc();
    req = req & ~ack; mem_ack = 1'b0;

    // timeout abort and re-grant
    settle();
    vblank = 1'b1; req = 4'b0001; req_addr0 = 22'h2ABCDE;
    cyc();
    n = 1;
    while (!err && n < 200) begin
      cyc();
      n++;
    end
    check("to_latency", 32'(n), 32'd64);
    check("to_drop", 32'(mem_req), 32'd0);
    cyc();
    check("regrant", 32'(grant), 32'h1);
    mem_ack = 1'b1;
    cyc();
    req = '0; mem_ack = 1'b0;

    // three owned active slots missed in one frame
    settle();
    vblank = 1'b0; hblank = 1'b0;
    ce_pixel = 1'b1; vcnt = 9'd0; hcnt = 9'd0;
    cyc();
    ce_pixel = 1'b0; vcnt = 9'd5;
    cyc();
    req = 4'b0001; ce_pixel = 1'b1; hcnt = 9'd4;
    cyc();
    check("miss_grant", 32'(grant), 32'h1);
    for (int k = 0; k < 10; k++) begin
      ce_pixel = (k == 2 || k == 5 || k == 8);
      hcnt = (k < 4) ? 9'd8 : (k < 7) ? 9'd12 : 9'd16;
      mem_ack = (k == 9);
      cyc();
    end
    mem_ack = 1'b0; req = '0;
    ce_pixel = 1'b1; vcnt = 9'd0; hcnt = 9'd0;
    cyc();
    check("miss_last3", 32'(miss_last), 32'd3);
    ce_pixel = 1'b0;
    cyc();
    ce_pixel = 1'b1;
    cyc();
    check("miss_restart", 32'(miss_last), 32'd0);
    ce_pixel = 1'b0;

    // reset while busy
    settle();
    vblank = 1'b1; req = 4'b0010;
    cyc();
    cyc();
    reset_n = 1'b0;
    cyc();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_miss_last", 32'(miss_last), 32'd0);
    reset_n = 1'b1; req = '0;

    // randomized traffic with varying memory latency
    for (int seg = 0; seg < 12; seg++) begin
      for (int c = 0; c < 250; c++) begin
        rand_drive((seg % 3 == 0) ? 0 : (seg % 3 == 1) ? 30 : 100);
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_mem_scheduler.md
# video_mem_scheduler

Arbitrates the single shared graphics-memory port between four requesters: BG layer 0, BG layer 1, the sprite engine and the CPU-side DMA. It uses the raster position and blanking flags from the video timing generator. During active display, access uses fixed per-pixel time slots. During blanking, access uses position-dependent fixed priority. Only one transaction is outstanding at a time, with a timeout abort and per-frame missed-slot statistics.

## Interface
- `TIMEOUT`, default 63: cycles in BUSY without `mem_ack` before abort (range 1..255).
- `AW`, default 22: address width of the requester and memory ports.

- `clk` in 1: system clock.
- `reset_n` in 1: reset; synchronous, active-low.
- `ce_pixel` in 1: pixel clock enable from video timing.
- `hcnt` in 9: horizontal counter, 0..423.
- `vcnt` in 9: vertical counter, 0..261.
- `hblank` in 1: horizontal blank flag.
- `vblank` in 1: vertical blank flag.
- `req` in 4: request per requester; bit 0=bg0, 1=bg1, 2=sprite, 3=cpu.
- `req_addr0` .. `req_addr3` in AW each: request address per requester.
- `ack` out 4: one-cycle completion pulse per requester.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_addr` out AW: address of the granted requester.
- `mem_ack` in 1: memory completion; one cycle.
- `grant` out 4: one-hot owner of the current transaction; 0 when idle.
- `err` out 1: one-cycle pulse on timeout abort.
- `miss_last` out 16: missed active slots in the previous frame.

## Operation
- Requesters hold `req[n]` and `req_addr{n}` stable from assertion until `ack[n]`.
- Two-state FSM:
  - IDLE: an arbitration decision is evaluated each cycle. A winner moves the FSM to BUSY.
  - BUSY: waits for `mem_ack` or a timeout.
- Region selection uses the input flags directly:
  - active: `!hblank && !vblank`
  - hblank: `hblank && !vblank`
  - vblank: `vblank`
- Active-region arbitration:
  - A decision is taken only on cycles where `ce_pixel=1`. The slot is `hcnt[1:0]`.
  - Slot 0 belongs to bg0, slot 1 to bg1, slot 2 to sprite.
  - Slot 3 is round-robin among pending bg0/bg1/sprite. The pointer starts after the last slot-3 winner. Reset value: bg0 highest.
  - The CPU never wins in the active region.
  - If the slot owner is not requesting, slots 0–2 stay idle; no other requester is substituted.
- Hblank arbitration: decision on any cycle; priority sprite > bg0 > bg1. The CPU is excluded.
- Vblank arbitration: decision on any cycle; priority cpu > sprite > bg0 > bg1.
- Missed slots: count slots where `ce_pixel=1` in the active region, the slot owner is requesting, and the FSM is BUSY.
  - Slots 0–2: the owner is the fixed requester.
  - Slot 3: any of bg0/bg1/sprite requesting counts as a miss.
  - The counter is 16 bits and saturates at 0xFFFF.
- Frame boundary: on `ce_pixel` with `vcnt==0 && hcnt==0`, the counter value is copied into `miss_last` and the counter is cleared. A miss in that same cycle counts toward the new frame (counter becomes 1).
- Timeout: a BUSY cycle counter reaching `TIMEOUT` with no `mem_ack` causes an abort.
  - Next state is IDLE; `mem_req`=0, `grant`=0, `err` pulses for one cycle.
  - No `ack` is issued, and the requester remains pending.
  - A `mem_ack` in the same cycle as the timeout wins: completion, no `err`.
- A request dropped while BUSY is still completed on the memory port. `ack` still pulses and may be ignored.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `grant`=0, `ack`=0, `err`=0, `miss_last`=0, miss counter 0, FSM IDLE, round-robin pointer at bg0.
- Decision in IDLE at cycle T: at T+1, `grant`, `mem_addr` and `mem_req`=1 are all registered and the FSM is BUSY.
- `mem_ack` sampled at cycle A: at A+1, `ack[owner]`=1 (one cycle), `mem_req`=0, `grant`=0, FSM IDLE.
- Earliest next decision is at A+1, giving a minimum request-to-request spacing of 2 cycles.
- `mem_addr` keeps its last value when idle.
- `mem_ack` is ignored in IDLE.
- Region and slot are evaluated from the inputs on the decision cycle. A blank edge during BUSY does not affect the current transaction.
- `err` asserts at cycle T+1+`TIMEOUT` relative to a decision at T.
- Reset asserted mid-transaction: all state returns to reset values at the next edge, with no `ack` and no `err`.

## Test plan
- Active region, all four requesting, `mem_ack` one cycle after `mem_req`, four consecutive `ce_pixel` at `hcnt`=8..11 -> grants bg0, bg1, sprite, then bg0 (round-robin); the CPU is never granted.
- Vblank with `req`=4'b1111 and immediate `mem_acks` -> grant order cpu, sprite, bg0, bg1; each `ack` pulse is exactly one cycle.
- Hblank with `req`=4'b1100 -> sprite granted and the CPU starved until `vblank` rises, then the CPU is granted.
- No `mem_ack` with `TIMEOUT`=63 -> `err` pulse at decision+64 cycles, `mem_req` drops, the same requester is re-granted at the next eligible decision.
- Memory holds BUSY for 10 cycles across 3 owned active slots during one frame -> at the next `vcnt`=0/`hcnt`=0 `ce_pixel`, `miss_last`=3 and the counter restarts.
- Assert `reset_n`=0 while BUSY -> next cycle `mem_req`=0, `grant`=0, `ack`=0, `miss_last`=0.
